// File: rtl/axi4_stream_cap_pkg.sv
// Shared types and constants for the AXI4-Stream capture sink.
// Ready-mode encoding and the LFSR used for pseudo-random backpressure.
package axi4_stream_cap_pkg;

  typedef enum logic [1:0] {
    RDY_ALWAYS   = 2'd0,
    RDY_NEVER    = 2'd1,
    RDY_PERIODIC = 2'd2,
    RDY_RANDOM   = 2'd3
  } rdy_mode_e;

  localparam int LFSR_W = 16;
  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] nxt;
    nxt = s >> 1;
    if (s[0]) begin
      nxt = nxt ^ LFSR_POLY;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/axi4_stream_rdy_gen.sv
// TREADY pattern generator: always/never, periodic duty cycle, or LFSR bit 0.
// The period counter free-runs in every mode so mode switches do not re-phase it.
module axi4_stream_rdy_gen
  import axi4_stream_cap_pkg::*;
(
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       ctl_clr,
  input  logic [1:0] ctl_mode,
  input  logic [7:0] ctl_per,
  input  logic [7:0] ctl_on,
  output logic       gen
);

  rdy_mode_e         mode_s;
  logic [7:0]        per_cnt_r;
  logic [LFSR_W-1:0] lfsr_r;

  assign mode_s = rdy_mode_e'(ctl_mode);

  // Period counter and LFSR state
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      per_cnt_r <= 8'd0;
      lfsr_r    <= LFSR_SEED;
    end else if (ctl_clr) begin
      per_cnt_r <= 8'd0;
      lfsr_r    <= LFSR_SEED;
    end else begin
      // >= so that shrinking ctl_per below the current count still wraps
      per_cnt_r <= (per_cnt_r >= ctl_per) ? 8'd0 : per_cnt_r + 8'd1;
      if (mode_s == RDY_RANDOM) begin
        lfsr_r <= lfsr_step(lfsr_r);
      end else begin
        lfsr_r <= lfsr_r;
      end
    end
  end

  // Mode decode
  always_comb begin
    gen = 1'b0;
    case (mode_s)
      RDY_ALWAYS:   gen = 1'b1;
      RDY_NEVER:    gen = 1'b0;
      RDY_PERIODIC: gen = (per_cnt_r < ctl_on);
      RDY_RANDOM:   gen = lfsr_r[0];
      default:      gen = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi4_stream_cap.sv
// AXI4-Stream capture sink: stores accepted beats in a dual-port buffer
// readable by address, with beat/packet counters and overflow status.
module axi4_stream_cap
  import axi4_stream_cap_pkg::*;
#(
  parameter int DN = 1,
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [DN*DW-1:0] TDATA,
  input  logic [DN-1:0]    TKEEP,
  input  logic             TLAST,
  input  logic             TVALID,
  output logic             TREADY,
  input  logic [1:0]       ctl_mode,
  input  logic [7:0]       ctl_per,
  input  logic [7:0]       ctl_on,
  input  logic             ctl_wrap,
  input  logic             ctl_clr,
  input  logic [AW-1:0]    rd_adr,
  output logic [DN*DW-1:0] rd_dat,
  output logic [DN-1:0]    rd_kep,
  output logic             rd_lst,
  output logic [AW:0]      sts_cnt,
  output logic [AW-1:0]    sts_wp,
  output logic [15:0]      sts_pkt,
  output logic             sts_ovf
);

  localparam int DEPTH = 2 ** AW;
  localparam int WD    = DN * DW + DN + 1;
  localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);

  logic [WD-1:0] mem_r [DEPTH];
  logic [WD-1:0] rd_q_r;
  logic          tready_r;
  logic [AW:0]   cnt_r;
  logic [AW:0]   cnt_nxt_s;
  logic [AW-1:0] wp_r;
  logic [15:0]   pkt_r;
  logic          ovf_r;
  logic          gen_s;
  logic          full_s;
  logic          wr_en_s;

  axi4_stream_rdy_gen u_rdy_gen (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .ctl_clr  (ctl_clr),
    .ctl_mode (ctl_mode),
    .ctl_per  (ctl_per),
    .ctl_on   (ctl_on),
    .gen      (gen_s)
  );

  assign full_s  = (cnt_r == FULL_C);
  // Beats coinciding with reset or clear are dropped, never stored
  assign wr_en_s = TVALID & tready_r & ARESETn & ~ctl_clr & (ctl_wrap | ~full_s);

  // Occupancy after the current cycle's transfer, saturating at DEPTH
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (wr_en_s && !full_s) begin
      cnt_nxt_s = cnt_r + (AW + 1)'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Pointers, counters, status and the TREADY flop
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      tready_r <= 1'b0;
      cnt_r    <= '0;
      wp_r     <= '0;
      pkt_r    <= 16'd0;
      ovf_r    <= 1'b0;
    end else if (ctl_clr) begin
      tready_r <= 1'b0;
      cnt_r    <= '0;
      wp_r     <= '0;
      pkt_r    <= 16'd0;
      ovf_r    <= 1'b0;
    end else begin
      tready_r <= gen_s & ~(~ctl_wrap & (cnt_nxt_s == FULL_C));
      cnt_r    <= cnt_nxt_s;
      if (wr_en_s) begin
        wp_r <= wp_r + AW'(1);
      end
      if (wr_en_s && TLAST && (pkt_r != 16'hFFFF)) begin
        pkt_r <= pkt_r + 16'd1;
      end
      if (wr_en_s && full_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Buffer write port
  always_ff @(posedge ACLK) begin
    if (wr_en_s) begin
      mem_r[wp_r] <= {TDATA, TKEEP, TLAST};
    end
  end

  // Buffer read port, read-before-write on address collision
  always_ff @(posedge ACLK) begin
    rd_q_r <= mem_r[rd_adr];
  end

  assign TREADY  = tready_r;
  assign rd_dat  = rd_q_r[WD-1 -: DN*DW];
  assign rd_kep  = rd_q_r[DN:1];
  assign rd_lst  = rd_q_r[0];
  assign sts_cnt = cnt_r;
  assign sts_wp  = wp_r;
  assign sts_pkt = pkt_r;
  assign sts_ovf = ovf_r;

endmodule

// File: tb/tb_axi4_stream_cap.sv
// Directed bench for axi4_stream_cap (DN=1, DW=8, AW=3): status checks inline,
// buffer read-back checked by a queue-based monitor.
module tb_axi4_stream_cap;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic [7:0] TDATA;
  logic [0:0] TKEEP;
  logic       TLAST;
  logic       TVALID;
  logic       TREADY;
  logic [1:0] ctl_mode;
  logic [7:0] ctl_per;
  logic [7:0] ctl_on;
  logic       ctl_wrap;
  logic       ctl_clr;
  logic [2:0] rd_adr;
  logic [7:0] rd_dat;
  logic [0:0] rd_kep;
  logic       rd_lst;
  logic [3:0] sts_cnt;
  logic [2:0] sts_wp;
  logic [15:0] sts_pkt;
  logic       sts_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  logic       rd_issue = 1'b0;
  logic [9:0] exp_q[$];
  int         adr_q[$];
  logic [9:0] sbq[$];

  axi4_stream_cap #(.DN(1), .DW(8), .AW(3)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .TDATA(TDATA), .TKEEP(TKEEP), .TLAST(TLAST),
    .TVALID(TVALID), .TREADY(TREADY), .ctl_mode(ctl_mode), .ctl_per(ctl_per),
    .ctl_on(ctl_on), .ctl_wrap(ctl_wrap), .ctl_clr(ctl_clr), .rd_adr(rd_adr),
    .rd_dat(rd_dat), .rd_kep(rd_kep), .rd_lst(rd_lst), .sts_cnt(sts_cnt),
    .sts_wp(sts_wp), .sts_pkt(sts_pkt), .sts_ovf(sts_ovf)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Read monitor: an address seen at one edge is compared after the next edge
  initial begin
    logic [9:0] e;
    int a;
    forever begin
      @(posedge ACLK);
      if (rd_issue) begin
        @(posedge ACLK);
        #1;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: got %0h expected none", {rd_dat, rd_kep, rd_lst});
        end else begin
          e = exp_q.pop_front();
          a = adr_q.pop_front();
          if ({rd_dat, rd_kep, rd_lst} !== e) begin
            n_fail++;
            $display("FAIL rd_adr%0d: got %0h expected %0h", a, {rd_dat, rd_kep, rd_lst}, e);
          end
        end
      end
    end
  end

  task automatic rd(input int adr, input logic [9:0] e);
    @(negedge ACLK);
    rd_adr = 3'(adr);
    exp_q.push_back(e);
    adr_q.push_back(adr);
    rd_issue = 1'b1;
    @(negedge ACLK);
    rd_issue = 1'b0;
    @(negedge ACLK);
  endtask

  // Source holds each beat until accepted; keep = even index, last = index%5==4
  task automatic run_src(input int n, input logic [7:0] base, input int budget, output int acc);
    int idx;
    logic x;
    idx = 0;
    @(negedge ACLK);
    for (int c = 0; c < budget && idx < n; c++) begin
      TVALID = 1'b1;
      TDATA  = base + 8'(idx);
      TKEEP  = 1'((idx % 2) == 0);
      TLAST  = ((idx % 5) == 4);
      x = TREADY;
      @(negedge ACLK);
      if (x) idx++;
    end
    TVALID = 1'b0;
    acc = idx;
  endtask

  task automatic do_clr();
    @(negedge ACLK);
    TVALID  = 1'b0;
    ctl_clr = 1'b1;
    @(negedge ACLK);
    ctl_clr = 1'b0;
  endtask

  task automatic status(input string nm, input int cnt, input int wp, input int pkt, input int ovf);
    check({nm, "_cnt"}, 32'(sts_cnt), 32'(cnt));
    check({nm, "_wp"},  32'(sts_wp),  32'(wp));
    check({nm, "_pkt"}, 32'(sts_pkt), 32'(pkt));
    check({nm, "_ovf"}, 32'(sts_ovf), 32'(ovf));
  endtask

  initial begin
    int acc, idx, npk, n, k0;
    logic x, exp_tr;
    logic [15:0] m;

    ARESETn = 1'b0; TDATA = 8'd0; TKEEP = 1'b0; TLAST = 1'b0; TVALID = 1'b0;
    ctl_mode = 2'd0; ctl_per = 8'd0; ctl_on = 8'd0; ctl_wrap = 1'b0; ctl_clr = 1'b0;
    rd_adr = 3'd0;

    // Reset state
    repeat (2) @(negedge ACLK);
    @(posedge ACLK); #1;
    check("rst_tready", 32'(TREADY), 32'd0);
    status("rst", 0, 0, 0, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check("first_tready", 32'(TREADY), 32'd1);

    // No-wrap fill: only 8 of 10 beats accepted
    run_src(10, 8'h00, 20, acc);
    check("nowrap_acc", 32'(acc), 32'd8);
    check("nowrap_tready", 32'(TREADY), 32'd0);
    status("nowrap", 8, 0, 1, 0);
    for (int i = 0; i < 8; i++) rd(i, {8'(i), 1'((i % 2) == 0), (i % 5) == 4});

    // Circular overwrite
    @(negedge ACLK);
    ctl_wrap = 1'b1;
    do_clr();
    check("clr_tready", 32'(TREADY), 32'd0);
    status("clr", 0, 0, 0, 0);
    run_src(10, 8'hA0, 40, acc);
    check("wrap_acc", 32'(acc), 32'd10);
    status("wrap", 8, 2, 2, 1);
    rd(0, {8'hA8, 1'b1, 1'b0});
    rd(1, {8'hA9, 1'b0, 1'b1});
    for (int i = 2; i < 8; i++) rd(i, {8'hA0 + 8'(i), 1'((i % 2) == 0), (i % 5) == 4});

    // Clear during a transfer discards the beat
    @(negedge ACLK);
    check("pre_clr_tready", 32'(TREADY), 32'd1);
    ctl_clr = 1'b1; TVALID = 1'b1; TDATA = 8'h77; TKEEP = 1'b1; TLAST = 1'b1;
    @(posedge ACLK); #1;
    check("clrx_tready", 32'(TREADY), 32'd0);
    status("clrx", 0, 0, 0, 0);
    @(negedge ACLK);
    ctl_clr = 1'b0; TVALID = 1'b0;
    @(posedge ACLK); #1;
    check("clrx_tready_back", 32'(TREADY), 32'd1);
    rd(2, {8'hA2, 1'b1, 1'b0});

    // Reset in the middle of a packet
    @(negedge ACLK);
    ctl_wrap = 1'b0;
    run_src(3, 8'h30, 10, acc);
    check("mid_acc", 32'(acc), 32'd3);
    check("mid_cnt", 32'(sts_cnt), 32'd3);
    @(negedge ACLK);
    ARESETn = 1'b0; TVALID = 1'b1; TDATA = 8'h33; TKEEP = 1'b1; TLAST = 1'b0;
    @(posedge ACLK); #1;
    check("mid_rst_tready", 32'(TREADY), 32'd0);
    status("mid_rst", 0, 0, 0, 0);
    @(negedge ACLK);
    ARESETn = 1'b1; TVALID = 1'b0;
    @(posedge ACLK); #1;
    check("mid_rel_tready", 32'(TREADY), 32'd1);
    rd(0, {8'h30, 1'b1, 1'b0});
    rd(1, {8'h31, 1'b0, 1'b0});
    rd(2, {8'h32, 1'b1, 1'b0});

    // Periodic 1-of-4 ready, four 3-beat packets over 48 cycles
    @(negedge ACLK);
    ctl_mode = 2'd2; ctl_per = 8'd3; ctl_on = 8'd1; ctl_wrap = 1'b1;
    do_clr();
    idx = 0;
    for (int k = 1; k <= 48; k++) begin
      TVALID = 1'b1;
      TDATA  = 8'h60 + 8'(idx);
      TKEEP  = 1'b1;
      TLAST  = ((idx % 3) == 2);
      x = TREADY;
      @(negedge ACLK);
      if (x) idx++;
      check($sformatf("per_tready_%0d", k), 32'(TREADY), 32'(((k - 1) % 4) == 0));
    end
    TVALID = 1'b0;
    check("per_acc", 32'(idx), 32'd12);
    status("per", 8, 4, 4, 1);

    // Random ready against an independent LFSR model, random source
    @(negedge ACLK);
    ctl_mode = 2'd3; ctl_wrap = 1'b1;
    do_clr();
    m = 16'hACE1;
    exp_tr = 1'b0;
    npk = 0;
    for (int c = 0; c < 1000; c++) begin
      check("rnd_tready", 32'(TREADY), 32'(exp_tr));
      TVALID = 1'($urandom_range(0, 1));
      TDATA  = 8'($urandom_range(0, 255));
      TKEEP  = 1'($urandom_range(0, 1));
      TLAST  = 1'($urandom_range(0, 1));
      x = TVALID & TREADY;
      @(negedge ACLK);
      if (x) begin
        sbq.push_back({TDATA, TKEEP, TLAST});
        if (TLAST) npk++;
      end
      exp_tr = m[0];
      m = m[0] ? ((m >> 1) ^ 16'hB400) : (m >> 1);
    end
    TVALID = 1'b0;
    n = sbq.size();
    status("rnd", (n >= 8) ? 8 : n, n % 8, npk, (n > 8) ? 1 : 0);
    k0 = (n > 8) ? n - 8 : 0;
    for (int k = k0; k < n; k++) rd(k % 8, sbq[k]);

    // NEVER mode holds TREADY low
    @(negedge ACLK);
    ctl_mode = 2'd1;
    repeat (2) @(negedge ACLK);
    check("never_tready", 32'(TREADY), 32'd0);

    repeat (3) @(negedge ACLK);
    check("rd_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
